univ_shift_reg: RTL and testbench

Parametrised universal shift register. Supports serial-in/serial-out, serial-in/parallel-out, parallel-in/serial-out and parallel-in/parallel-out in one block. Data moves LANE bits per shift, in either direction. A beat counter marks completion of a full frame (WIDTH/LANE shifts). The block serves as the generic shifting element for serialiser/deserialiser paths in the design.

---
 rtl/univ_shift_reg.sv | 112 +++++++++++
 tb/tb_univ_shift_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift (either direction, LANE bits per
// beat) / parallel load / clear, with a beat counter that flags the end of
// each WIDTH/LANE-shift frame. Serves SISO, SIPO, PISO and PIPO uses.
module univ_shift_reg #(
  parameter int              WIDTH     = 12,
  parameter int              LANE      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   dir,
  input  logic [LANE-1:0]        ser_in,
  input  logic [WIDTH-1:0]       par_in,
  output logic [LANE-1:0]        ser_out,
  output logic [WIDTH-1:0]       par_out,
  output logic [((WIDTH/LANE) > 1 ? $clog2(WIDTH/LANE) : 1)-1:0] beat_cnt,
  output logic                   frame_done
);

  localparam int BEATS = WIDTH / LANE;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] BEAT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] BEAT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // Reject geometries where a frame is not a whole number of lanes.
  generate
    if (WIDTH < 2 || LANE < 1 || LANE >= WIDTH || (WIDTH % LANE) != 0) begin : g_bad_params
      $error("univ_shift_reg: need WIDTH>=2, 1<=LANE<WIDTH and WIDTH%%LANE==0");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_beat;
  logic             r_fd;

  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    w_beat_nxt;
  logic             w_fd_nxt;

  // Next-state selection for contents, beat counter and frame pulse.
  always_comb begin
    w_q_nxt    = r_q;
    w_beat_nxt = r_beat;
    w_fd_nxt   = 1'b0;
    case (mode)
      MODE_HOLD: begin
        w_q_nxt    = r_q;
        w_beat_nxt = r_beat;
        w_fd_nxt   = 1'b0;
      end
      MODE_SHIFT: begin
        if (dir) begin
          w_q_nxt = {r_q[WIDTH-LANE-1:0], ser_in};
        end else begin
          w_q_nxt = {ser_in, r_q[WIDTH-1:LANE]};
        end
        // Counter is shared by both directions; it wraps to zero at the
        // frame boundary so the next frame starts without a gap cycle.
        if (r_beat == LAST_BEAT) begin
          w_beat_nxt = BEAT_ZERO;
          w_fd_nxt   = 1'b1;
        end else begin
          w_beat_nxt = r_beat + BEAT_ONE;
          w_fd_nxt   = 1'b0;
        end
      end
      MODE_LOAD: begin
        w_q_nxt    = par_in;
        w_beat_nxt = BEAT_ZERO;
        w_fd_nxt   = 1'b0;
      end
      MODE_CLEAR: begin
        w_q_nxt    = RESET_VAL;
        w_beat_nxt = BEAT_ZERO;
        w_fd_nxt   = 1'b0;
      end
      default: begin
        w_q_nxt    = r_q;
        w_beat_nxt = r_beat;
        w_fd_nxt   = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= RESET_VAL;
      r_beat <= BEAT_ZERO;
      r_fd   <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_beat <= w_beat_nxt;
      r_fd   <= w_fd_nxt;
    end
  end

  // The outgoing lane is visible before the edge so PISO data is valid in
  // the same cycle the shift is requested.
  assign ser_out    = dir ? r_q[WIDTH-1:WIDTH-LANE] : r_q[LANE-1:0];
  assign par_out    = r_q;
  assign beat_cnt   = r_beat;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: two instances (LANE=1 with
// RESET_VAL=12'h3C3, LANE=3 with RESET_VAL=0) driven from shared controls.
module tb_univ_shift_reg;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic        dir;
  logic        ser_in1;
  logic [2:0]  ser_in3;
  logic [11:0] par_in;

  logic        ser_out1;
  logic [11:0] par_out1;
  logic [3:0]  beat1;
  logic        fd1;
  logic [2:0]  ser_out3;
  logic [11:0] par_out3;
  logic [1:0]  beat3;
  logic        fd3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic        sel3;
    logic        cs;
    logic [2:0]  es;
    logic [11:0] ep;
    logic [3:0]  eb;
    logic        ef;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  logic have_pend = 1'b0;

  univ_shift_reg #(.WIDTH(12), .LANE(1), .RESET_VAL(12'h3C3)) u1 (
    .clk(clk), .reset(reset), .mode(mode), .dir(dir), .ser_in(ser_in1),
    .par_in(par_in), .ser_out(ser_out1), .par_out(par_out1),
    .beat_cnt(beat1), .frame_done(fd1)
  );

  univ_shift_reg #(.WIDTH(12), .LANE(3), .RESET_VAL(12'h000)) u3 (
    .clk(clk), .reset(reset), .mode(mode), .dir(dir), .ser_in(ser_in3),
    .par_in(par_in), .ser_out(ser_out3), .par_out(par_out3),
    .beat_cnt(beat3), .frame_done(fd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks post-edge state of the previous entry at negedge, then
  // pops the next entry and checks its pre-edge ser_out.
  initial begin
    forever begin
      @(negedge clk);
      if (have_pend) begin
        if (pend.sel3) begin
          chk({pend.tag, " par3"}, par_out3, pend.ep);
          chk({pend.tag, " beat3"}, {10'd0, beat3}, {8'd0, pend.eb});
          chk({pend.tag, " fd3"}, {11'd0, fd3}, {11'd0, pend.ef});
        end else begin
          chk({pend.tag, " par1"}, par_out1, pend.ep);
          chk({pend.tag, " beat1"}, {8'd0, beat1}, {8'd0, pend.eb});
          chk({pend.tag, " fd1"}, {11'd0, fd1}, {11'd0, pend.ef});
        end
        have_pend = 1'b0;
      end
      #3;
      if (sb.size() > 0) begin
        pend = sb.pop_front();
        have_pend = 1'b1;
        if (pend.cs) begin
          if (pend.sel3) chk({pend.tag, " ser3"}, {9'd0, ser_out3}, {9'd0, pend.es});
          else           chk({pend.tag, " ser1"}, {11'd0, ser_out1}, {11'd0, pend.es});
        end
      end
    end
  end

  task automatic step(input string tag, input logic [1:0] m, input logic d,
                      input logic [2:0] si, input logic [11:0] pi, input logic sel3,
                      input logic cs, input logic [2:0] es, input logic [11:0] ep,
                      input logic [3:0] eb, input logic ef);
    exp_t e;
    @(negedge clk);
    #1;
    mode = m; dir = d; ser_in1 = si[0]; ser_in3 = si; par_in = pi;
    e.tag = tag; e.sel3 = sel3; e.cs = cs; e.es = es;
    e.ep = ep; e.eb = eb; e.ef = ef;
    sb.push_back(e);
  endtask

  // Mid-cycle asynchronous reset pulse; checked before any clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, " rst par1"}, par_out1, 12'h3C3);
    chk({tag, " rst beat1"}, {8'd0, beat1}, 12'h000);
    chk({tag, " rst fd1"}, {11'd0, fd1}, 12'h000);
    chk({tag, " rst par3"}, par_out3, 12'h000);
    chk({tag, " rst beat3"}, {10'd0, beat3}, 12'h000);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [11:0] v;
    logic [11:0] exp_v;
    reset = 1'b0; mode = 2'b00; dir = 1'b0; ser_in1 = 1'b0; ser_in3 = 3'b000;
    par_in = 12'h000;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset value: load something else, then reset mid-cycle.
    step("ld123", 2'b10, 1'b0, 3'b000, 12'h123, 1'b0, 1'b1, 3'd1, 12'h123, 4'd0, 1'b0);
    step("hold0", 2'b00, 1'b0, 3'b000, 12'h000, 1'b0, 1'b0, 3'd0, 12'h123, 4'd0, 1'b0);
    pulse_reset("t1");

    // SIPO shift right after loading A5C.
    step("ldA5C", 2'b10, 1'b0, 3'b000, 12'hA5C, 1'b0, 1'b1, 3'd1, 12'hA5C, 4'd0, 1'b0);
    step("sr1", 2'b01, 1'b0, 3'b000, 12'h000, 1'b0, 1'b1, 3'd0, 12'h52E, 4'd1, 1'b0);
    step("sr2", 2'b01, 1'b0, 3'b000, 12'h000, 1'b0, 1'b1, 3'd0, 12'h297, 4'd2, 1'b0);
    step("sr3", 2'b01, 1'b0, 3'b000, 12'h000, 1'b0, 1'b1, 3'd1, 12'h14B, 4'd3, 1'b0);
    step("sr4", 2'b01, 1'b0, 3'b000, 12'h000, 1'b0, 1'b1, 3'd1, 12'h0A5, 4'd4, 1'b0);

    // Frame done, LANE=3 shift left with 3'b101.
    step("clr3", 2'b11, 1'b1, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd0, 1'b0);
    step("sl1", 2'b01, 1'b1, 3'b101, 12'h000, 1'b1, 1'b1, 3'd0, 12'h005, 4'd1, 1'b0);
    step("sl2", 2'b01, 1'b1, 3'b101, 12'h000, 1'b1, 1'b1, 3'd0, 12'h02D, 4'd2, 1'b0);
    step("sl3", 2'b01, 1'b1, 3'b101, 12'h000, 1'b1, 1'b1, 3'd0, 12'h16D, 4'd3, 1'b0);
    step("sl4", 2'b01, 1'b1, 3'b101, 12'h000, 1'b1, 1'b1, 3'd0, 12'hB6D, 4'd0, 1'b1);
    step("slh", 2'b00, 1'b1, 3'b000, 12'h000, 1'b1, 1'b1, 3'd5, 12'hB6D, 4'd0, 1'b0);

    // Back-to-back frames, LANE=3 shift right with 3'b011.
    step("clr3b", 2'b11, 1'b0, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd0, 1'b0);
    step("bb1", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd0, 12'h600, 4'd1, 1'b0);
    step("bb2", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd0, 12'h6C0, 4'd2, 1'b0);
    step("bb3", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd0, 12'h6D8, 4'd3, 1'b0);
    step("bb4", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd0, 12'h6DB, 4'd0, 1'b1);
    step("bb5", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd3, 12'h6DB, 4'd1, 1'b0);
    step("bb6", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd3, 12'h6DB, 4'd2, 1'b0);
    step("bb7", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd3, 12'h6DB, 4'd3, 1'b0);
    step("bb8", 2'b01, 1'b0, 3'b011, 12'h000, 1'b1, 1'b1, 3'd3, 12'h6DB, 4'd0, 1'b1);
    step("bbh", 2'b00, 1'b0, 3'b000, 12'h000, 1'b1, 1'b1, 3'd3, 12'h6DB, 4'd0, 1'b0);

    // Direction changes do not restart the shared beat counter.
    step("clr3c", 2'b11, 1'b0, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd0, 1'b0);
    step("dc1", 2'b01, 1'b1, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd1, 1'b0);
    step("dc2", 2'b01, 1'b0, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd2, 1'b0);
    step("dc3", 2'b01, 1'b1, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd3, 1'b0);
    step("dc4", 2'b01, 1'b0, 3'b000, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 4'd0, 1'b1);

    // Load restarts the frame (LANE=1).
    step("clr1", 2'b11, 1'b1, 3'b000, 12'h000, 1'b0, 1'b0, 3'd0, 12'h3C3, 4'd0, 1'b0);
    step("pre1", 2'b01, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd0, 12'h786, 4'd1, 1'b0);
    step("pre2", 2'b01, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd0, 12'hF0C, 4'd2, 1'b0);
    step("pre3", 2'b01, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd1, 12'hE18, 4'd3, 1'b0);
    step("pre4", 2'b01, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd1, 12'hC30, 4'd4, 1'b0);
    step("pre5", 2'b01, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd1, 12'h860, 4'd5, 1'b0);
    step("ldFFF", 2'b10, 1'b1, 3'b000, 12'hFFF, 1'b0, 1'b1, 3'd1, 12'hFFF, 4'd0, 1'b0);
    v = 12'hFFF;
    for (int k = 1; k <= 12; k++) begin
      exp_v = v << k;
      step("piso", 2'b01, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd1, exp_v,
           4'(k % 12), (k == 12));
    end
    step("pisoh", 2'b00, 1'b1, 3'b000, 12'h000, 1'b0, 1'b1, 3'd0, 12'h000, 4'd0, 1'b0);

    // Hold and reset mid-frame (LANE=1).
    step("clr1b", 2'b11, 1'b0, 3'b000, 12'h000, 1'b0, 1'b0, 3'd0, 12'h3C3, 4'd0, 1'b0);
    step("hr1", 2'b01, 1'b0, 3'b001, 12'h000, 1'b0, 1'b1, 3'd1, 12'h9E1, 4'd1, 1'b0);
    step("hr2", 2'b01, 1'b0, 3'b001, 12'h000, 1'b0, 1'b1, 3'd1, 12'hCF0, 4'd2, 1'b0);
    step("hr3", 2'b01, 1'b0, 3'b001, 12'h000, 1'b0, 1'b1, 3'd0, 12'hE78, 4'd3, 1'b0);
    step("hh1", 2'b00, 1'b0, 3'b001, 12'hABC, 1'b0, 1'b1, 3'd0, 12'hE78, 4'd3, 1'b0);
    step("hh2", 2'b00, 1'b0, 3'b001, 12'hABC, 1'b0, 1'b1, 3'd0, 12'hE78, 4'd3, 1'b0);
    pulse_reset("t6");
    v = 12'h3C3;
    for (int k = 1; k <= 12; k++) begin
      exp_v = v >> k;
      step("post", 2'b01, 1'b0, 3'b000, 12'h000, 1'b0, 1'b1,
           {2'b00, exp_v[0] ^ exp_v[0] ^ ((v >> (k - 1)) & 12'h001) != 12'h000},
           exp_v, 4'(k % 12), (k == 12));
    end
    step("posth", 2'b00, 1'b0, 3'b000, 12'h000, 1'b0, 1'b1, 3'd0, 12'h000, 4'd0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && (sb.size() > 0 || have_pend); i++) @(negedge clk);
    #4;
    chk("drain", {11'd0, (sb.size() == 0 && !have_pend)}, 12'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
